// File: rtl/probe_channel_mux_if.sv
// probe_channel_mux_if
//   Groups the channel-select, probe data and status signals of
//   probe_channel_mux into one bundle.
//   master : drives sel, sel_load, din, err_clr; observes the status outputs
//   slave  : the mux itself
//   sel        one-hot channel request, applied on sel_load
//   din        N_CH channels of W bits, channel k at din[k*W +: W]
//   err_clr    clears sel_err
//   dout       registered data of the active channel (0 unless dout_valid)
//   dout_valid dout carries channel data
//   active_ch  binary index of the active channel
//   busy       blanking in progress
//   sel_err    sticky invalid-select flag
//   act_cnt    saturating transition count on bit 0 of the active channel
interface probe_channel_mux_if #(
  parameter int N_CH = 8,
  parameter int W    = 1,
  parameter int CW   = 16
);
  localparam int AW = $clog2(N_CH);

  logic [N_CH-1:0]   sel;
  logic              sel_load;
  logic [N_CH*W-1:0] din;
  logic              err_clr;
  logic [W-1:0]      dout;
  logic              dout_valid;
  logic [AW-1:0]     active_ch;
  logic              busy;
  logic              sel_err;
  logic [CW-1:0]     act_cnt;

  modport master (
    output sel, sel_load, din, err_clr,
    input  dout, dout_valid, active_ch, busy, sel_err, act_cnt
  );

  modport slave (
    input  sel, sel_load, din, err_clr,
    output dout, dout_valid, active_ch, busy, sel_err, act_cnt
  );
endinterface

// File: rtl/probe_channel_mux.sv
// probe_channel_mux
//   Selects one of N_CH probe channels onto a registered output. A channel
//   switch is followed by BLANK cycles of blanking before data is shown.
//   While running, transitions on bit 0 of the active channel are counted.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : probe_channel_mux_if.slave (sel/sel_load/din/err_clr in,
//          dout/dout_valid/active_ch/busy/sel_err/act_cnt out)
module probe_channel_mux #(
  parameter int N_CH  = 8,
  parameter int W     = 1,
  parameter int BLANK = 4,
  parameter int CW    = 16
) (
  input  logic               clk,
  input  logic               rst,
  probe_channel_mux_if.slave bus
);

  localparam int AW = $clog2(N_CH);
  localparam int BW = $clog2(BLANK + 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ch_q, ch_d;
  logic [BW-1:0] bc_q, bc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ref_q, ref_d;
  logic          ref_ok_q, ref_ok_d;
  logic          err_q, err_d;
  logic [W-1:0]  dout_q;
  logic          dv_q;

  logic          sel_ok;
  logic [AW-1:0] sel_idx;
  logic          load_ok;
  logic          load_bad;
  logic [W-1:0]  ch_data [N_CH];
  logic [W-1:0]  cur;

  // One-hot check and binary encode of sel in one pass.
  always_comb begin
    int unsigned ones;
    ones    = 0;
    sel_idx = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (bus.sel[k]) begin
        ones    = ones + 1;
        sel_idx = AW'(k);
      end
    end
    sel_ok = (ones == 1);
  end

  assign load_ok  = bus.sel_load & sel_ok;
  assign load_bad = bus.sel_load & ~sel_ok;

  always_comb begin
    for (int unsigned k = 0; k < N_CH; k++) begin
      ch_data[k] = bus.din[k*W +: W];
    end
  end

  assign cur = ch_data[ch_q];

  // Next-state logic. A valid load overrides whatever the current state
  // would otherwise do; an invalid load only touches the error flag.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    bc_d     = bc_q;
    cnt_d    = cnt_q;
    ref_d    = ref_q;
    ref_ok_d = ref_ok_q;

    if (load_ok) begin
      ch_d     = sel_idx;
      bc_d     = BW'(BLANK);
      cnt_d    = '0;
      ref_ok_d = 1'b0;
      state_d  = (BLANK == 0) ? S_RUN : S_BLANK;
    end else begin
      case (state_q)
        S_BLANK: begin
          bc_d = (bc_q == '0) ? '0 : bc_q - BW'(1);
          if (bc_q <= BW'(1)) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          // First RUN edge only establishes the reference bit.
          ref_d    = cur[0];
          ref_ok_d = 1'b1;
          if (ref_ok_q && (cur[0] != ref_q) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end

    // Setting wins over clearing when both happen in one cycle.
    if (load_bad) begin
      err_d = 1'b1;
    end else if (bus.err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      bc_q     <= '0;
      cnt_q    <= '0;
      ref_q    <= 1'b0;
      ref_ok_q <= 1'b0;
      err_q    <= 1'b0;
      dout_q   <= '0;
      dv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      bc_q     <= bc_d;
      cnt_q    <= cnt_d;
      ref_q    <= ref_d;
      ref_ok_q <= ref_ok_d;
      err_q    <= err_d;
      dout_q   <= (state_q == S_RUN) ? cur : '0;
      dv_q     <= (state_q == S_RUN);
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.active_ch  = ch_q;
  assign bus.busy       = (state_q == S_BLANK);
  assign bus.sel_err    = err_q;
  assign bus.act_cnt    = cnt_q;

endmodule

// File: tb/tb_probe_channel_mux.sv
// tb_probe_channel_mux
//   Three instances: A (BLANK=4, W=1, CW=16), B (BLANK=0, W=2),
//   C (BLANK=4, CW=3, act_cnt only). Expected outputs are queued when
//   stimulus is driven and compared #1 after the following rising edge.
module tb_probe_channel_mux;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  probe_channel_mux_if #(.N_CH(8), .W(1), .CW(16)) ia ();
  probe_channel_mux_if #(.N_CH(8), .W(2), .CW(16)) ib ();
  probe_channel_mux_if #(.N_CH(8), .W(1), .CW(3))  ic ();

  probe_channel_mux #(.N_CH(8), .W(1), .BLANK(4), .CW(16)) u_a (.clk(clk), .rst(rst), .bus(ia));
  probe_channel_mux #(.N_CH(8), .W(2), .BLANK(0), .CW(16)) u_b (.clk(clk), .rst(rst), .bus(ib));
  probe_channel_mux #(.N_CH(8), .W(1), .BLANK(4), .CW(3))  u_c (.clk(clk), .rst(rst), .bus(ic));

  typedef struct {
    logic [31:0] dout;
    logic        dv;
    logic [31:0] ach;
    logic        busy;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    logic       ld;
    logic [7:0] sel;
    logic [7:0] din;
    logic       clr;
    exp_t       e;
  } vec_t;

  exp_t        qa[$];
  exp_t        qb[$];
  int unsigned qc[$];
  vec_t        tbl [15];
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic exp_t mk(int d, int v, int a, int b, int er, int c);
    exp_t e;
    e.dout = 32'(d);
    e.dv   = v[0];
    e.ach  = 32'(a);
    e.busy = b[0];
    e.err  = er[0];
    e.cnt  = 32'(c);
    return e;
  endfunction

  function automatic vec_t row(logic ld, logic [7:0] s, logic [7:0] d, logic c, exp_t e);
    vec_t r;
    r.ld  = ld;
    r.sel = s;
    r.din = d;
    r.clr = c;
    r.e   = e;
    return r;
  endfunction

  task automatic cmp(input string nm, input exp_t e, input logic [31:0] d, input logic v,
                     input logic [31:0] a, input logic b, input logic er, input logic [31:0] c);
    n_vec++;
    if (d !== e.dout || v !== e.dv || a !== e.ach || b !== e.busy || er !== e.err || c !== e.cnt) begin
      n_bad++;
      $display("FAIL %s: got dout=%0h valid=%0b ch=%0d busy=%0b err=%0b cnt=%0d, want dout=%0h valid=%0b ch=%0d busy=%0b err=%0b cnt=%0d",
               nm, d, v, a, b, er, c, e.dout, e.dv, e.ach, e.busy, e.err, e.cnt);
    end
  endtask

  task automatic check_a(input string nm);
    exp_t e;
    if (qa.size() == 0) begin
      n_vec++; n_bad++;
      $display("FAIL %s: no expectation queued for A", nm);
    end else begin
      e = qa.pop_front();
      cmp(nm, e, 32'(ia.dout), ia.dout_valid, 32'(ia.active_ch), ia.busy, ia.sel_err, 32'(ia.act_cnt));
    end
  endtask

  task automatic check_b(input string nm);
    exp_t e;
    if (qb.size() == 0) begin
      n_vec++; n_bad++;
      $display("FAIL %s: no expectation queued for B", nm);
    end else begin
      e = qb.pop_front();
      cmp(nm, e, 32'(ib.dout), ib.dout_valid, 32'(ib.active_ch), ib.busy, ib.sel_err, 32'(ib.act_cnt));
    end
  endtask

  task automatic check_c(input string nm);
    int unsigned w;
    n_vec++;
    if (qc.size() == 0) begin
      n_bad++;
      $display("FAIL %s: no expectation queued for C", nm);
    end else begin
      w = qc.pop_front();
      if (32'(ic.act_cnt) !== w) begin
        n_bad++;
        $display("FAIL %s: got act_cnt=%0d, want act_cnt=%0d", nm, ic.act_cnt, w);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_a(input string nm, input logic ld, input logic [7:0] s,
                        input logic [7:0] d, input logic c, input exp_t e);
    ia.sel_load = ld;
    ia.sel      = s;
    ia.din      = d;
    ia.err_clr  = c;
    qa.push_back(e);
    tick();
    check_a(nm);
  endtask

  task automatic step_ac(input string nm, input logic ld, input logic [7:0] s,
                         input logic [7:0] d, input exp_t e, input int unsigned cc);
    ic.sel_load = ld;
    ic.sel      = s;
    ic.din      = d;
    ic.err_clr  = 1'b0;
    qc.push_back(cc);
    step_a(nm, ld, s, d, 1'b0, e);
    check_c({nm, "_c"});
  endtask

  task automatic step_b(input string nm, input logic ld, input logic [7:0] s,
                        input logic [15:0] d, input exp_t e);
    ib.sel_load = ld;
    ib.sel      = s;
    ib.din      = d;
    ib.err_clr  = 1'b0;
    qb.push_back(e);
    tick();
    check_b(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    int unsigned bitv;
    logic [7:0]  d;

    // Channel-2 bring-up, data tracking, invalid loads and err_clr.
    tbl[0]  = row(1'b1, 8'h04, 8'h04, 1'b0, mk(0, 0, 2, 1, 0, 0));
    tbl[1]  = row(1'b0, 8'h00, 8'h04, 1'b0, mk(0, 0, 2, 1, 0, 0));
    tbl[2]  = row(1'b0, 8'h00, 8'h04, 1'b0, mk(0, 0, 2, 1, 0, 0));
    tbl[3]  = row(1'b0, 8'h00, 8'h04, 1'b0, mk(0, 0, 2, 1, 0, 0));
    tbl[4]  = row(1'b0, 8'h00, 8'h04, 1'b0, mk(0, 0, 2, 0, 0, 0));
    tbl[5]  = row(1'b0, 8'h00, 8'hFB, 1'b0, mk(0, 1, 2, 0, 0, 0));
    tbl[6]  = row(1'b0, 8'h00, 8'h04, 1'b0, mk(1, 1, 2, 0, 0, 1));
    tbl[7]  = row(1'b0, 8'h00, 8'h04, 1'b0, mk(1, 1, 2, 0, 0, 1));
    tbl[8]  = row(1'b0, 8'h00, 8'hFF, 1'b0, mk(1, 1, 2, 0, 0, 1));
    tbl[9]  = row(1'b0, 8'h00, 8'h00, 1'b0, mk(0, 1, 2, 0, 0, 2));
    tbl[10] = row(1'b1, 8'h06, 8'h00, 1'b0, mk(0, 1, 2, 0, 1, 2));
    tbl[11] = row(1'b1, 8'h00, 8'h04, 1'b0, mk(1, 1, 2, 0, 1, 3));
    tbl[12] = row(1'b0, 8'h00, 8'h04, 1'b1, mk(1, 1, 2, 0, 0, 3));
    tbl[13] = row(1'b1, 8'h06, 8'h04, 1'b1, mk(1, 1, 2, 0, 1, 3));
    tbl[14] = row(1'b0, 8'h00, 8'h04, 1'b1, mk(1, 1, 2, 0, 0, 3));

    rst = 1'b1;
    ia.sel = '0; ia.sel_load = 1'b0; ia.din = '0; ia.err_clr = 1'b0;
    ib.sel = '0; ib.sel_load = 1'b0; ib.din = '0; ib.err_clr = 1'b0;
    ic.sel = '0; ic.sel_load = 1'b0; ic.din = '0; ic.err_clr = 1'b0;
    repeat (2) tick();
    qa.push_back(mk(0, 0, 0, 0, 0, 0)); check_a("reset_a");
    qb.push_back(mk(0, 0, 0, 0, 0, 0)); check_b("reset_b");
    qc.push_back(0);                    check_c("reset_c");
    rst = 1'b0;

    // Row 0 lands on the first edge after reset release.
    for (int i = 0; i < 15; i++) begin
      step_a($sformatf("vec%0d", i), tbl[i].ld, tbl[i].sel, tbl[i].din, tbl[i].clr, tbl[i].e);
    end

    // Blanking restart: ch0 then ch7; ch0 data (din=01) must never show.
    step_a("rs_ld0",  1'b1, 8'h01, 8'h01, 1'b0, mk(0, 1, 0, 1, 0, 0));
    step_a("rs_b1",   1'b0, 8'h00, 8'h01, 1'b0, mk(0, 0, 0, 1, 0, 0));
    step_a("rs_ld7",  1'b1, 8'h80, 8'h01, 1'b0, mk(0, 0, 7, 1, 0, 0));
    for (int i = 0; i < 3; i++) begin
      step_a($sformatf("rs_bl%0d", i), 1'b0, 8'h00, 8'h01, 1'b0, mk(0, 0, 7, 1, 0, 0));
    end
    step_a("rs_run",  1'b0, 8'h00, 8'h01, 1'b0, mk(0, 0, 7, 0, 0, 0));
    step_a("rs_val",  1'b0, 8'h00, 8'h81, 1'b0, mk(1, 1, 7, 0, 0, 0));
    step_a("rs_tr",   1'b0, 8'h00, 8'h01, 1'b0, mk(0, 1, 7, 0, 0, 1));

    // Activity counting on ch3; C saturates at 7.
    step_ac("ac_ld", 1'b1, 8'h08, 8'h00, mk(0, 1, 3, 1, 0, 0), 0);
    for (int i = 0; i < 3; i++) begin
      step_ac($sformatf("ac_bl%0d", i), 1'b0, 8'h00, 8'h00, mk(0, 0, 3, 1, 0, 0), 0);
    end
    step_ac("ac_run", 1'b0, 8'h00, 8'h00, mk(0, 0, 3, 0, 0, 0), 0);
    step_ac("ac_ref", 1'b0, 8'h00, 8'h00, mk(0, 1, 3, 0, 0, 0), 0);
    for (int i = 0; i < 10; i++) begin
      bitv = (i % 2 == 0) ? 1 : 0;
      d = 8'(bitv << 3);
      step_ac($sformatf("ac_tg%0d", i), 1'b0, 8'h00, d, mk(int'(bitv), 1, 3, 0, 0, i + 1),
              (i + 1 > 7) ? 7 : i + 1);
    end
    for (int i = 0; i < 4; i++) begin
      step_ac($sformatf("ac_hold%0d", i), 1'b0, 8'h00, 8'h00, mk(0, 1, 3, 0, 0, 10), 7);
    end
    step_ac("ac_reload", 1'b1, 8'h08, 8'h00, mk(0, 1, 3, 1, 0, 0), 0);
    ia.sel_load = 1'b0; ic.sel_load = 1'b0;

    // No blanking, 2-bit channels.
    step_b("b_ld1",  1'b1, 8'h02, 16'h000C, mk(0, 0, 1, 0, 0, 0));
    step_b("b_d3",   1'b0, 8'h00, 16'h000C, mk(3, 1, 1, 0, 0, 0));
    step_b("b_d1",   1'b0, 8'h00, 16'h0004, mk(1, 1, 1, 0, 0, 0));
    step_b("b_d2",   1'b0, 8'h00, 16'h0008, mk(2, 1, 1, 0, 0, 1));
    step_b("b_bad",  1'b1, 8'h03, 16'h0008, mk(2, 1, 1, 0, 1, 1));
    step_b("b_ld5",  1'b1, 8'h20, 16'h0C00, mk(0, 1, 5, 0, 1, 0));
    step_b("b_d5",   1'b0, 8'h00, 16'h0C00, mk(3, 1, 5, 0, 1, 0));
    ib.sel_load = 1'b0;

    // Asynchronous reset mid-BLANK, load concurrent with release, reset mid-RUN.
    step_a("r_ld0",  1'b1, 8'h01, 8'h00, 1'b0, mk(0, 1, 0, 1, 0, 0));
    step_a("r_bad",  1'b1, 8'h03, 8'h00, 1'b0, mk(0, 0, 0, 1, 1, 0));
    ia.sel_load = 1'b0;
    #3 rst = 1'b1;
    #1;
    qa.push_back(mk(0, 0, 0, 0, 0, 0)); check_a("rst_mid_blank");
    qb.push_back(mk(0, 0, 0, 0, 0, 0)); check_b("rst_b");
    ia.sel_load = 1'b1; ia.sel = 8'h01; ia.din = 8'h01;
    qa.push_back(mk(0, 0, 0, 0, 0, 0));
    tick();
    check_a("rst_hold_load");
    rst = 1'b0;
    step_a("rel_load", 1'b1, 8'h01, 8'h01, 1'b0, mk(0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 3; i++) begin
      step_a($sformatf("rel_bl%0d", i), 1'b0, 8'h00, 8'h01, 1'b0, mk(0, 0, 0, 1, 0, 0));
    end
    step_a("rel_run", 1'b0, 8'h00, 8'h01, 1'b0, mk(0, 0, 0, 0, 0, 0));
    step_a("rel_v0",  1'b0, 8'h00, 8'h01, 1'b0, mk(1, 1, 0, 0, 0, 0));
    step_a("rel_v1",  1'b0, 8'h00, 8'h01, 1'b0, mk(1, 1, 0, 0, 0, 0));
    #3 rst = 1'b1;
    #1;
    qa.push_back(mk(0, 0, 0, 0, 0, 0)); check_a("rst_mid_run");
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = (i % 2 == 0) ? 8'hFF : 8'h00;
      step_a($sformatf("idle%0d", i), 1'b0, 8'h01, d, 1'b0, mk(0, 0, 0, 0, 0, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/probe_channel_mux.md
PROBE_CHANNEL_MUX -- requirements
Module: probe_channel_mux

Interface
REQ-001 Parameter N_CH, default 8, number of probe channels (>=2).
REQ-002 Parameter W, default 1, bit width of each channel.
REQ-003 Parameter BLANK, default 4, blanking cycles after a channel switch (>=0).
REQ-004 Parameter CW, default 16, width of the activity counter.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 sel  input  N_CH  one-hot channel request, sampled only when sel_load=1.
REQ-008 sel_load  input  1  single-cycle strobe that applies sel.
REQ-009 din  input  N_CH*W  channel k occupies din[k*W +: W].
REQ-010 err_clr  input  1  clears sel_err.
REQ-011 dout  output  W  registered data of the active channel; 0 when not valid.
REQ-012 dout_valid  output  1  dout carries channel data.
REQ-013 active_ch  output  $clog2(N_CH)  binary index of the active channel; 0 in IDLE.
REQ-014 busy  output  1  high while in BLANK.
REQ-015 sel_err  output  1  sticky flag: an invalid sel was loaded.
REQ-016 act_cnt  output  CW  count of transitions on bit 0 of the active channel.

Function
REQ-017 FSM SHALL have states IDLE (no channel), BLANK, and RUN.
REQ-018 sel is valid only when exactly one bit is set; zero or multi-hot values SHALL be invalid.
REQ-019 A valid sel_load in any state SHALL latch the channel, load blank_cnt=BLANK, clear act_cnt, and enter BLANK, or enter RUN directly if BLANK=0.
REQ-020 In BLANK, blank_cnt SHALL decrement each cycle; the edge at which blank_cnt==1 SHALL move the FSM to RUN.
REQ-021 A valid sel_load during BLANK SHALL restart blanking with the new channel.
REQ-022 An invalid sel_load SHALL set sel_err and leave the state, channel, blank_cnt and act_cnt unchanged.
REQ-023 Each edge SHALL register dout <= (state==RUN) ? active channel din : 0 and dout_valid <= (state==RUN).
  - Latency from a sel_load edge to the first dout_valid edge SHALL be BLANK+1 cycles.
REQ-024 In RUN, act_cnt SHALL increment on each edge where bit 0 of the active channel differs from its value at the previous edge.
  - The first RUN cycle only captures the reference value and SHALL NOT count.
  - act_cnt SHALL saturate at 2^CW-1.
REQ-025 sel_err SHALL clear on err_clr; if an invalid load and err_clr occur in the same cycle, set SHALL win.
REQ-026 busy SHALL equal (state==BLANK) and SHALL be combinational from the state register.
REQ-027 The block SHALL NOT leave IDLE except through a valid sel_load.

Reset
REQ-028 While rst=1, and immediately on its assertion:
  - state=IDLE, active_ch=0, blank_cnt=0
  - dout=0, dout_valid=0, busy=0
  - sel_err=0, act_cnt=0
REQ-029 Reset during BLANK or RUN SHALL abort the operation and discard the latched channel.
REQ-030 The first edge after rst deasserts SHALL honour a concurrent sel_load.

Verification
REQ-031 Reset, then sel=8'h04 with sel_load at edge 0, BLANK=4 -> busy=1 for edges 1-4; dout_valid=1 and active_ch=2 from edge 5; dout tracks din[2] with 1-cycle delay.
REQ-032 In RUN on channel 2, sel_load with sel=8'h06, then sel=8'h00 -> sel_err=1, channel 2 still output, dout_valid stays 1; err_clr -> sel_err=0.
REQ-033 sel_load with 8'h01, then sel_load with 8'h80 two cycles later -> blanking restarts; first valid on channel 7 appears 5 cycles after the second load; channel 0 data never appears.
REQ-034 BLANK=0 with sel_load 8'h02 -> dout_valid=1 one cycle later, busy never asserted.
REQ-035 In RUN, toggle din[ch] bit 0 for 10 cycles, then hold it -> act_cnt=10 (or 9 if the toggling started in the first RUN cycle); with CW=3 it saturates at 7; a new valid load clears act_cnt to 0.
REQ-036 Assert rst mid-BLANK, then mid-RUN -> all outputs 0 at once without waiting for a clock edge; state IDLE after release.
